fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Upstream stage of the multicycle MIPS control path. Owns the program counter (PC), the instruction register (IR) and the latched branch target.
- Supplies opcode and instruction fields to the main FSM controller.
- Updates PC/IR according to the controller's 4-bit state code.
- Drives the memory address for instruction fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, width of PC, branch target and memory address.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- state  in  4  controller state code: S0=0 (fetch), S1=1 (decode), S8=8 (BEQ), S11=11 (J), S12=12 (BNE); other codes are non-PC states.
- mem_rdata  in  32  instruction word returned by memory, valid combinationally in the same cycle as fetch_addr.
- alu_zero  in  1  ALU zero flag from the rs-rt compare in the branch states.
- fetch_addr  out  ADDR_W  memory address for fetch; equals PC.
- fetch_en  out  1  high when state==S0.
- pc  out  ADDR_W  current PC register.
- opcode  out  6  IR[31:26].
- rs, rt, rd  out  5 each  IR[25:21], IR[20:16], IR[15:11].
- funct  out  6  IR[5:0].
- imm_sext  out  32  sign-extended IR[15:0].
- branch_taken  out  1  one-cycle pulse, registered, when a branch/jump updated PC.

Behaviour:
- Reset (asynchronous, any cycle, including mid-instruction): PC=RESET_PC, IR=0, branch target=0, branch_taken=0. Consequences: opcode=0, imm_sext=0, fetch_en follows state.
- S0:
  - IR <= mem_rdata.
  - PC <= PC+4, modulo 2^ADDR_W; wraps from 32'hFFFF_FFFC to 0.
  - One-cycle fetch: the new opcode is visible the cycle after S0, i.e. during S1.
- S1: btgt <= PC + (sext(IR[15:0]) << 2). Uses the already incremented PC; wrap-around modulo 2^ADDR_W.
- S8 (BEQ): if alu_zero=1, PC <= btgt and branch_taken <= 1; otherwise PC is unchanged.
- S12 (BNE): if alu_zero=0, PC <= btgt and branch_taken <= 1; otherwise PC is unchanged.
- S11 (J): PC <= {PC[31:28], IR[25:0], 2'b00}; branch_taken <= 1.
- Every other state code (2-7, 9, 10, 13-15): PC, IR and btgt hold. Codes 13-15 are illegal and never modify PC.
- branch_taken: 0 in every cycle not listed above. Registered, so it is asserted in the cycle after the branch state.
- Field outputs are combinational slices of IR. They stay stable from the cycle after S0 until the next S0.
- Simultaneous events: only one state code is present per cycle, so there are no update conflicts. Reset dominates everything.
- PC is always word aligned. RESET_PC[1:0] must be 0; a nonzero value is a configuration error, and the low bits are forced to 0.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds output instr_count (32 bits), which increments on every S0 cycle.
  - Adds output taken_count (32 bits), which increments on every branch_taken pulse.
  - Both counters reset to 0 and wrap at 2^32.
- Undefined: neither port nor counter exists. All other behaviour is identical.

Test Plan:
- Reset: assert rst mid-S1 with PC=0x40 -> PC returns to 0 asynchronously. Opcode=0 at the next edge, with no wait for a clock.
- Fetch: S0 with mem_rdata=0x8C220004 (LW) and PC=0 -> next cycle PC=4, opcode=6'b100011, rs=1, rt=2, imm_sext=4.
- BEQ taken: IR imm=0xFFFF, PC=0x10 after fetch, S1, then S8 with alu_zero=1 -> PC=0x0C and branch_taken pulses exactly one cycle.
- BNE not taken: S12 with alu_zero=1 -> PC unchanged and branch_taken stays 0. Repeat with alu_zero=0 and imm=2 from PC=0x20 -> PC=0x28.
- Jump: PC=0x40000004, IR=0x08000010, S11 -> PC=0x40000040.
- Wrap and perf counters (FETCH_PERF_CNT_EN): PC=0xFFFFFFFC with S0 -> PC=0 and instr_count increments by 1. Run 3 fetches plus 1 taken branch -> instr_count=4 (3 fetches plus the wrap fetch), taken_count=1.

Source files
------------

// File: rtl/fetch_pc_unit_if.sv
// rtl/fetch_pc_unit_if.sv - instruction fetch bus between fetch_pc_unit and instruction memory
interface fetch_pc_unit_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_en;
  logic [31:0]       mem_rdata;

  // fetch unit drives the address/enable and consumes the returned word
  modport master (
    output fetch_addr,
    output fetch_en,
    input  mem_rdata
  );

  // memory side
  modport slave (
    input  fetch_addr,
    input  fetch_en,
    output mem_rdata
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - multicycle MIPS PC/IR/branch-target owner (optional FETCH_PERF_CNT_EN counters)
module fetch_pc_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        state,
  input  logic              alu_zero,
  fetch_pc_unit_if.master   mem_if,
  output logic [ADDR_W-1:0] pc,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [5:0]        funct,
  output logic [31:0]       imm_sext,
  output logic              branch_taken
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       instr_count,
  output logic [31:0]       taken_count
`endif
);

  // controller state codes that touch PC/IR/btgt; everything else holds
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_BEQ    = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_BNE    = 4'd12;

  // a misaligned reset vector is a configuration error; keep PC word aligned anyway
  localparam logic [ADDR_W-1:0] RESET_PC_ALIGNED = {RESET_PC[ADDR_W-1:2], 2'b00};
  localparam logic [ADDR_W-1:0] PC_STEP          = ADDR_W'(4);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [ADDR_W-1:0] btgt_q, btgt_d;
  logic              branch_taken_q, branch_taken_d;
  logic [ADDR_W-1:0] br_off;

  // word offset of a branch: sign-extended immediate scaled by 4
  assign br_off = {{(ADDR_W-18){ir_q[15]}}, ir_q[15:0], 2'b00};

  // next-state of PC, IR, branch target and taken pulse from the controller state
  always_comb begin
    pc_d           = pc_q;
    ir_d           = ir_q;
    btgt_d         = btgt_q;
    branch_taken_d = 1'b0;
    case (state)
      S_FETCH: begin
        ir_d = mem_if.mem_rdata;
        pc_d = pc_q + PC_STEP;
      end
      S_DECODE: begin
        btgt_d = pc_q + br_off;
      end
      S_BEQ: begin
        if (alu_zero) begin
          pc_d           = btgt_q;
          branch_taken_d = 1'b1;
        end
      end
      S_BNE: begin
        if (!alu_zero) begin
          pc_d           = btgt_q;
          branch_taken_d = 1'b1;
        end
      end
      S_JUMP: begin
        pc_d           = {pc_q[ADDR_W-1:28], ir_q[25:0], 2'b00};
        branch_taken_d = 1'b1;
      end
      default: ;
    endcase
  end

  // architectural registers; reset may land mid-instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q           <= RESET_PC_ALIGNED;
      ir_q           <= '0;
      btgt_q         <= '0;
      branch_taken_q <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      ir_q           <= ir_d;
      btgt_q         <= btgt_d;
      branch_taken_q <= branch_taken_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] instr_count_q, instr_count_d;
  logic [31:0] taken_count_q, taken_count_d;

  // fetch and taken-branch event counters, free-running with wrap
  always_comb begin
    instr_count_d = instr_count_q;
    taken_count_d = taken_count_q;
    if (state == S_FETCH) begin
      instr_count_d = instr_count_q + 32'd1;
    end
    if (branch_taken_d) begin
      taken_count_d = taken_count_q + 32'd1;
    end
  end

  // counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_count_q <= '0;
      taken_count_q <= '0;
    end else begin
      instr_count_q <= instr_count_d;
      taken_count_q <= taken_count_d;
    end
  end

  assign instr_count = instr_count_q;
  assign taken_count = taken_count_q;
`endif

  assign mem_if.fetch_addr = pc_q;
  assign mem_if.fetch_en   = (state == S_FETCH);
  assign pc                = pc_q;
  assign opcode            = ir_q[31:26];
  assign rs                = ir_q[25:21];
  assign rt                = ir_q[20:16];
  assign rd                = ir_q[15:11];
  assign funct             = ir_q[5:0];
  assign imm_sext          = {{16{ir_q[15]}}, ir_q[15:0]};
  assign branch_taken      = branch_taken_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed self-checking bench for fetch_pc_unit
module tb_fetch_pc_unit;
    logic        clk = 1'b0;
    logic        rst, rst_w, rst_j;
    logic [3:0]  state;
    logic        alu_zero;
    logic [31:0] rdata;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    fetch_pc_unit_if #(.ADDR_W(32)) bus_m ();
    fetch_pc_unit_if #(.ADDR_W(32)) bus_w ();
    fetch_pc_unit_if #(.ADDR_W(32)) bus_j ();

    assign bus_m.mem_rdata = rdata;
    assign bus_w.mem_rdata = rdata;
    assign bus_j.mem_rdata = rdata;

    logic [31:0] pc_m, pc_w, pc_j;
    logic [5:0]  opcode_m, opcode_w, opcode_j;
    logic [4:0]  rs_m, rs_w, rs_j, rt_m, rt_w, rt_j, rd_m, rd_w, rd_j;
    logic [5:0]  funct_m, funct_w, funct_j;
    logic [31:0] imm_m, imm_w, imm_j;
    logic        bt_m, bt_w, bt_j;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] ic_m, tc_m, ic_w, tc_w, ic_j, tc_j;
`endif

    fetch_pc_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut_m (
        .clk(clk), .rst(rst), .state(state), .alu_zero(alu_zero), .mem_if(bus_m),
        .pc(pc_m), .opcode(opcode_m), .rs(rs_m), .rt(rt_m), .rd(rd_m),
        .funct(funct_m), .imm_sext(imm_m), .branch_taken(bt_m)
`ifdef FETCH_PERF_CNT_EN
        , .instr_count(ic_m), .taken_count(tc_m)
`endif
    );

    fetch_pc_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFF)) dut_w (
        .clk(clk), .rst(rst_w), .state(state), .alu_zero(alu_zero), .mem_if(bus_w),
        .pc(pc_w), .opcode(opcode_w), .rs(rs_w), .rt(rt_w), .rd(rd_w),
        .funct(funct_w), .imm_sext(imm_w), .branch_taken(bt_w)
`ifdef FETCH_PERF_CNT_EN
        , .instr_count(ic_w), .taken_count(tc_w)
`endif
    );

    fetch_pc_unit #(.ADDR_W(32), .RESET_PC(32'h3FFF_FFFC)) dut_j (
        .clk(clk), .rst(rst_j), .state(state), .alu_zero(alu_zero), .mem_if(bus_j),
        .pc(pc_j), .opcode(opcode_j), .rs(rs_j), .rt(rt_j), .rd(rd_j),
        .funct(funct_j), .imm_sext(imm_j), .branch_taken(bt_j)
`ifdef FETCH_PERF_CNT_EN
        , .instr_count(ic_j), .taken_count(tc_j)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst      = 1'b1;
        rst_w    = 1'b1;
        rst_j    = 1'b1;
        state    = 4'd2;
        alu_zero = 1'b0;
        rdata    = 32'h0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("reset_pc", pc_m, 32'h0);
        chk("reset_opcode", opcode_m, 32'h0);
        chk("reset_imm", imm_m, 32'h0);
        chk("reset_bt", bt_m, 32'h0);
        chk("fetch_en_idle", bus_m.fetch_en, 32'h0);

        state = 4'd0;
        rdata = 32'h8C22_0004;
        #1;
        chk("fetch_en_s0", bus_m.fetch_en, 32'h1);
        chk("fetch_addr_s0", bus_m.fetch_addr, 32'h0);
        step();
        chk("lw_pc", pc_m, 32'h4);
        chk("lw_opcode", opcode_m, 32'h23);
        chk("lw_rs", rs_m, 32'd1);
        chk("lw_rt", rt_m, 32'd2);
        chk("lw_rd", rd_m, 32'd0);
        chk("lw_funct", funct_m, 32'd4);
        chk("lw_imm", imm_m, 32'h4);
        state = 4'd1;
        rdata = 32'hFFFF_FFFF;
        step();
        chk("decode_opcode_stable", opcode_m, 32'h23);
        chk("decode_pc_hold", pc_m, 32'h4);

        state = 4'd0;
        rdata = 32'h0;
        step();
        step();
        rdata = 32'h1022_FFFF;
        step();
        chk("beq_fetch_pc", pc_m, 32'h10);
        chk("beq_imm", imm_m, 32'hFFFF_FFFF);
        state = 4'd1;
        step();
        chk("beq_decode_pc", pc_m, 32'h10);
        state    = 4'd8;
        alu_zero = 1'b1;
        step();
        chk("beq_taken_pc", pc_m, 32'h0C);
        chk("beq_taken_bt", bt_m, 32'h1);
        state    = 4'd13;
        alu_zero = 1'b0;
        step();
        chk("illegal_pc_hold", pc_m, 32'h0C);
        chk("bt_one_cycle", bt_m, 32'h0);
        chk("illegal_ir_hold", opcode_m, 32'd4);

        state = 4'd0;
        rdata = 32'h0;
        repeat (4) step();
        rdata = 32'h1422_0002;
        step();
        chk("bne_fetch_pc", pc_m, 32'h20);
        state = 4'd1;
        step();
        state    = 4'd12;
        alu_zero = 1'b1;
        step();
        chk("bne_not_taken_pc", pc_m, 32'h20);
        chk("bne_not_taken_bt", bt_m, 32'h0);
        alu_zero = 1'b0;
        step();
        chk("bne_taken_pc", pc_m, 32'h28);
        chk("bne_taken_bt", bt_m, 32'h1);
        state = 4'd3;
        step();
        chk("bne_bt_clear", bt_m, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("main_instr_count", ic_m, 32'd9);
        chk("main_taken_count", tc_m, 32'd2);
`endif

        state = 4'd0;
        rdata = 32'h0;
        repeat (5) step();
        rdata = 32'h8C22_0004;
        step();
        chk("pre_reset_pc", pc_m, 32'h40);
        state = 4'd1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_reset_pc", pc_m, 32'h0);
        chk("async_reset_opcode", opcode_m, 32'h0);
        chk("async_reset_imm", imm_m, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("async_reset_count", ic_m, 32'd0);
`endif

        state = 4'd2;
        step();
        rst_w = 1'b0;
        #1;
        chk("align_reset_pc", pc_w, 32'hFFFF_FFFC);
        state = 4'd0;
        rdata = 32'h1000_0001;
        step();
        chk("wrap_pc", pc_w, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("wrap_instr_count", ic_w, 32'd1);
`endif
        state = 4'd1;
        step();
        state    = 4'd8;
        alu_zero = 1'b1;
        step();
        chk("wrap_beq_pc", pc_w, 32'h4);
        chk("wrap_beq_bt", bt_w, 32'h1);
        state    = 4'd0;
        alu_zero = 1'b0;
        rdata    = 32'h0;
        repeat (3) step();
        chk("wrap_walk_pc", pc_w, 32'h10);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_instr_count", ic_w, 32'd4);
        chk("perf_taken_count", tc_w, 32'd1);
`endif

        state = 4'd2;
        step();
        rst_j = 1'b0;
        #1;
        chk("jump_reset_pc", pc_j, 32'h3FFF_FFFC);
        state = 4'd0;
        rdata = 32'h0;
        step();
        rdata = 32'h0800_0010;
        step();
        chk("jump_fetch_pc", pc_j, 32'h4000_0004);
        state = 4'd11;
        step();
        chk("jump_pc", pc_j, 32'h4000_0040);
        chk("jump_bt", bt_j, 32'h1);
        state = 4'd2;
        step();
        chk("jump_bt_clear", bt_j, 32'h0);
        chk("jump_pc_hold", pc_j, 32'h4000_0040);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
